// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider, one quotient bit per clock.
// Independent dividend/divisor widths, optional two's-complement mode,
// divide-by-zero and signed-overflow flags, valid/ready on both sides.
module seq_divider #(
    parameter int DVD_W  = 16,
    parameter int DVS_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [DVD_W-1:0] dvd,
    input  logic [DVS_W-1:0] dvs,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [DVD_W-1:0] quo,
    output logic [DVS_W-1:0] rem,
    output logic             dbz,
    output logic             ovf
);

    localparam int CNT_W = $clog2(DVD_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);
    localparam logic [DVD_W-1:0] MOST_NEG  = {1'b1, {(DVD_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_FIX, S_ZERO, S_OVF, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // quo_q holds the dividend bits still to be consumed in its upper part and
    // the quotient bits produced so far in its lower part while in CALC.
    logic [DVD_W-1:0] quo_q, quo_d;
    // rem_q is the partial remainder during CALC and the final remainder after.
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             oval_q, oval_d;

    logic             accept;
    logic             is_ovf;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [DVD_W-1:0] dvd_mag;
    logic [DVS_W-1:0] dvs_mag;
    logic [DVS_W:0]   shifted;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            oval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            oval_q  <= oval_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dvs == '0)  state_d = S_ZERO;
                    else if (is_ovf) state_d = S_OVF;
                    else             state_d = S_CALC;
                end
            end
            S_CALC:                 if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX, S_ZERO, S_OVF:   state_d = S_DONE;
            S_DONE:                 if (oval_q && out_rdy) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Operand decode and datapath next values
    always_comb begin
        dvd_neg = (SIGNED != 0) && dvd[DVD_W-1];
        dvs_neg = (SIGNED != 0) && dvs[DVS_W-1];
        dvd_mag = dvd_neg ? -dvd : dvd;
        dvs_mag = dvs_neg ? -dvs : dvs;
        is_ovf  = (SIGNED != 0) && (dvd == MOST_NEG) && (dvs == '1);
        accept  = in_val && (state_q == S_IDLE);
        shifted = {rem_q, quo_q[DVD_W-1]};

        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;
        oval_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    rem_d  = '0;
                    dvs_d  = dvs_mag;
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    // The zero-divisor path reports the raw dividend bits, not the magnitude
                    quo_d  = (dvs == '0) ? dvd : dvd_mag;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d = DVS_W'(shifted - {1'b0, dvs_q});
                    quo_d = {quo_q[DVD_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DVS_W-1:0];
                    quo_d = {quo_q[DVD_W-2:0], 1'b0};
                end
            end
            S_FIX: begin
                if (qneg_q) quo_d = -quo_q;
                if (rneg_q) rem_d = -rem_q;
            end
            S_ZERO: begin
                quo_d = '1;
                rem_d = quo_q[DVS_W-1:0];
                dbz_d = 1'b1;
            end
            S_OVF: begin
                rem_d = '0;
                ovf_d = 1'b1;
            end
            S_DONE: begin
                // out_val is registered, rising one clock after DONE is entered
                if (oval_q && out_rdy) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                end else begin
                    oval_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Port outputs
    always_comb begin
        in_rdy  = (state_q == S_IDLE);
        out_val = oval_q;
        quo     = quo_q;
        rem     = rem_q;
        dbz     = dbz_q;
        ovf     = ovf_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider.
// Three instances (unsigned 16/16, signed 16/16, unsigned 24/8) share the
// operand buses and out_rdy; each has its own in_val.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] drv_dvd = '0;
    logic [15:0] drv_dvs = '0;
    logic        out_rdy = 1'b1;
    logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [15:0] q0, q1;
    logic [23:0] q2;
    logic [15:0] r0, r1;
    logic [7:0]  r2;
    logic        z0, z1, z2;
    logic        o0, o1, o2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider #(.DVD_W(16), .DVS_W(16), .SIGNED(0)) u_div_u16 (
        .clk(clk), .rst(rst), .in_val(iv0), .in_rdy(rdy0),
        .dvd(drv_dvd[15:0]), .dvs(drv_dvs), .out_val(ov0), .out_rdy(out_rdy),
        .quo(q0), .rem(r0), .dbz(z0), .ovf(o0)
    );

    seq_divider #(.DVD_W(16), .DVS_W(16), .SIGNED(1)) u_div_s16 (
        .clk(clk), .rst(rst), .in_val(iv1), .in_rdy(rdy1),
        .dvd(drv_dvd[15:0]), .dvs(drv_dvs), .out_val(ov1), .out_rdy(out_rdy),
        .quo(q1), .rem(r1), .dbz(z1), .ovf(o1)
    );

    seq_divider #(.DVD_W(24), .DVS_W(8), .SIGNED(0)) u_div_w24 (
        .clk(clk), .rst(rst), .in_val(iv2), .in_rdy(rdy2),
        .dvd(drv_dvd), .dvs(drv_dvs[7:0]), .out_val(ov2), .out_rdy(out_rdy),
        .quo(q2), .rem(r2), .dbz(z2), .ovf(o2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int s);
        case (s)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic oval_of(input int s);
        case (s)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [23:0] quo_of(input int s);
        case (s)
            0:       return {8'h00, q0};
            1:       return {8'h00, q1};
            default: return q2;
        endcase
    endfunction

    function automatic logic [15:0] rem_of(input int s);
        case (s)
            0:       return r0;
            1:       return r1;
            default: return {8'h00, r2};
        endcase
    endfunction

    function automatic logic dbz_of(input int s);
        case (s)
            0:       return z0;
            1:       return z1;
            default: return z2;
        endcase
    endfunction

    function automatic logic ovf_of(input int s);
        case (s)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    task automatic set_iv(input int s, input logic v);
        case (s)
            0:       iv0 = v;
            1:       iv1 = v;
            default: iv2 = v;
        endcase
    endtask

    // Reference: language-level division for each instance's configuration
    task automatic ref_div(input int s, input logic [23:0] a, input logic [15:0] b,
                           output logic [23:0] q, output logic [15:0] r,
                           output logic z, output logic o);
        int sa, sb;
        q = '0; r = '0; z = 1'b0; o = 1'b0;
        case (s)
            0: begin
                if (b == 16'h0) begin
                    q = 24'h00FFFF; r = a[15:0]; z = 1'b1;
                end else begin
                    q = {8'h00, a[15:0] / b};
                    r = a[15:0] % b;
                end
            end
            1: begin
                sa = int'($signed(a[15:0]));
                sb = int'($signed(b));
                if (sb == 0) begin
                    q = 24'h00FFFF; r = a[15:0]; z = 1'b1;
                end else if (sa == -32768 && sb == -1) begin
                    q = 24'h008000; r = 16'h0; o = 1'b1;
                end else begin
                    q = {8'h00, 16'(sa / sb)};
                    r = 16'(sa % sb);
                end
            end
            default: begin
                if (b[7:0] == 8'h0) begin
                    q = 24'hFFFFFF; r = {8'h00, a[7:0]}; z = 1'b1;
                end else begin
                    q = a / {16'h0, b[7:0]};
                    r = {8'h00, 8'(a % {16'h0, b[7:0]})};
                end
            end
        endcase
    endtask

    // One request/response; hold > 0 keeps out_rdy low that many cycles after out_val
    task automatic xact(input int s, input logic [23:0] a, input logic [15:0] b,
                        input int hold, input string tag);
        logic [23:0] eq, q_s;
        logic [15:0] er, r_s;
        logic        ez, eo;
        int          lat, busy_bad, stab_bad, exp_lat;
        ref_div(s, a, b, eq, er, ez, eo);
        exp_lat = (ez || eo) ? 2 : ((s == 2) ? 26 : 18);
        check_eq({tag, "/idle_rdy"}, 32'(rdy_of(s)), 32'd1);
        out_rdy = (hold == 0);
        drv_dvd = a;
        drv_dvs = b;
        set_iv(s, 1'b1);
        @(posedge clk); #1;
        set_iv(s, 1'b0);
        drv_dvd = 24'($urandom);
        drv_dvs = 16'($urandom);
        lat = 0;
        busy_bad = 0;
        while (!oval_of(s) && lat < 100) begin
            if (rdy_of(s)) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (rdy_of(s)) busy_bad++;
        check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "/busy_rdy"}, 32'(busy_bad), 32'd0);
        check_eq({tag, "/quo"}, 32'(quo_of(s)), 32'(eq));
        check_eq({tag, "/rem"}, 32'(rem_of(s)), 32'(er));
        check_eq({tag, "/dbz"}, 32'(dbz_of(s)), 32'(ez));
        check_eq({tag, "/ovf"}, 32'(ovf_of(s)), 32'(eo));
        if (hold > 0) begin
            q_s = quo_of(s);
            r_s = rem_of(s);
            stab_bad = 0;
            repeat (hold) begin
                set_iv(s, 1'b1);
                drv_dvd = 24'($urandom);
                drv_dvs = 16'($urandom);
                @(posedge clk); #1;
                if (!oval_of(s) || rdy_of(s) || quo_of(s) != q_s || rem_of(s) != r_s)
                    stab_bad++;
            end
            set_iv(s, 1'b0);
            check_eq({tag, "/hold_stable"}, 32'(stab_bad), 32'd0);
            out_rdy = 1'b1;
        end
        @(posedge clk); #1;
        check_eq({tag, "/val_drop"}, 32'(oval_of(s)), 32'd0);
    endtask

    task automatic rand_ops(input int s, output logic [23:0] a, output logic [15:0] b);
        int k;
        k = int'($urandom_range(0, 9));
        a = 24'($urandom);
        b = 16'($urandom);
        case (k)
            0: b = 16'h0;
            1: b = 16'($urandom_range(1, 15));
            2: begin a[15:0] = 16'h8000; b = 16'hFFFF; end
            3: b = 16'hFFFF;
            4: a[15:0] = 16'h8000;
            5: a = 24'($urandom_range(0, 20));
            default: ;
        endcase
        if (s == 2 && k == 1) b = 16'($urandom_range(1, 3));
    endtask

    initial begin
        logic [23:0] ra;
        logic [15:0] rb;
        int          late_val;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check_eq($sformatf("reset%0d/rdy", s), 32'(rdy_of(s)), 32'd1);
            check_eq($sformatf("reset%0d/val", s), 32'(oval_of(s)), 32'd0);
            check_eq($sformatf("reset%0d/quo", s), 32'(quo_of(s)), 32'd0);
            check_eq($sformatf("reset%0d/rem", s), 32'(rem_of(s)), 32'd0);
            check_eq($sformatf("reset%0d/flags", s), 32'({dbz_of(s), ovf_of(s)}), 32'd0);
        end
        rst = 1'b0;

        // Directed cases
        xact(0, 24'd100, 16'd7, 0, "u_100_7");
        xact(1, 24'h00FFF9, 16'd2, 0, "s_m7_2");
        xact(1, 24'd7, 16'hFFFE, 0, "s_7_m2");
        xact(0, 24'h1234, 16'h0, 0, "u_dbz");
        xact(1, 24'hFFF9, 16'h0, 0, "s_dbz_neg");
        xact(1, 24'h8000, 16'hFFFF, 0, "s_ovf");
        xact(1, 24'h8000, 16'h0001, 0, "s_mneg_1");
        xact(1, 24'h8000, 16'h0003, 0, "s_mneg_3");
        xact(2, 24'hFFFFFF, 16'h00FF, 0, "w_ff_ff");
        xact(2, 24'hABCDEF, 16'h0000, 0, "w_dbz");

        // Backpressure, then a request straight afterwards
        xact(0, 24'd1000, 16'd13, 10, "u_bp");
        xact(0, 24'd9, 16'd3, 0, "u_after_bp");
        xact(1, 24'h8000, 16'hFFFF, 5, "s_bp_ovf");

        // Reset during CALC aborts the request
        out_rdy = 1'b1;
        drv_dvd = 24'd1000;
        drv_dvs = 16'd7;
        iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst/rdy", 32'(rdy0), 32'd1);
        check_eq("midrst/val", 32'(ov0), 32'd0);
        check_eq("midrst/quo", 32'(q0), 32'd0);
        check_eq("midrst/rem", 32'(r0), 32'd0);
        late_val = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ov0) late_val++;
        end
        check_eq("midrst/no_result", 32'(late_val), 32'd0);
        xact(0, 24'd50, 16'd5, 0, "u_after_rst");

        // Randomized back-to-back traffic
        for (int i = 0; i < 1000; i++) begin
            rand_ops(0, ra, rb);
            xact(0, ra, rb, 0, "rnd_u16");
        end
        for (int i = 0; i < 1000; i++) begin
            rand_ops(1, ra, rb);
            xact(1, ra, rb, (i % 97 == 5) ? 3 : 0, "rnd_s16");
        end
        for (int i = 0; i < 200; i++) begin
            rand_ops(2, ra, rb);
            xact(2, ra, rb, 0, "rnd_w24");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring integer divider; next generation of the team's single-width divider.
- Adds independent dividend/divisor widths, signed/unsigned mode, remainder output, divide-by-zero and overflow handling, and valid/ready handshakes on both sides.
- Sits between any arithmetic requester, e.g. a scaler or rate calculator, and its consumer.
- Computes one quotient bit per clock.

Parameters:
- DVD_W, 16, dividend and quotient width in bits (>=2).
- DVS_W, 16, divisor and remainder width in bits (>=2, <=DVD_W).
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands with quotient truncated toward zero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_val  in  1  request valid.
- in_rdy  out  1  divider can accept a request.
- dvd  in  DVD_W  dividend, sampled on acceptance.
- dvs  in  DVS_W  divisor, sampled on acceptance.
- out_val  out  1  result valid.
- out_rdy  in  1  consumer accepts result.
- quo  out  DVD_W  quotient.
- rem  out  DVS_W  remainder.
- dbz  out  1  divide-by-zero flag, qualified by out_val.
- ovf  out  1  signed overflow flag (most-negative / -1), qualified by out_val.

Behaviour:
- Reset values (rst high at a clk edge): state IDLE; in_rdy=1, out_val=0, quo=0, rem=0, dbz=0, ovf=0; iteration counter=0.
- Reset mid-operation aborts the computation. No out_val is produced for the aborted request.
- Acceptance: on a clk edge with in_val && in_rdy. in_rdy is combinationally 1 only in IDLE. dvd/dvs are registered at acceptance and may change afterwards.
- States and transitions:
  - IDLE: on acceptance -> ZERO if dvs==0; -> OVF if SIGNED and dvd==most-negative and dvs==all-ones; otherwise -> CALC. Counter cleared; |dvd| and |dvs| latched (plain values when SIGNED=0); result signs latched (q_neg = sign(dvd) XOR sign(dvs), r_neg = sign(dvd)).
  - CALC: exactly DVD_W cycles. Each cycle, shift the DVS_W+1-bit partial remainder left, bringing in the dividend MSB. If partial >= |dvs|, subtract and shift quotient bit 1; otherwise shift 0. After the DVD_W-th iteration -> FIX.
  - FIX: one cycle. Negate quotient if q_neg; negate remainder if r_neg (SIGNED=1 only). -> DONE.
  - ZERO: one cycle. quo=all ones, rem=dvd[DVS_W-1:0] (low bits of the dividend), dbz=1. -> DONE.
  - OVF: one cycle. quo=dvd (most negative), rem=0, ovf=1. -> DONE.
  - DONE: out_val=1; quo/rem/dbz/ovf held stable. -> IDLE on a clk edge with out_rdy=1. On that transition out_val drops and flags clear.
- Latency, counting the acceptance edge as edge 0 and assuming out_rdy=1:
  - normal case: out_val high after edge DVD_W+2;
  - ZERO/OVF: out_val high after edge 2.
- Throughput: the next request is accepted earliest on the edge after the result is consumed, i.e. the clock following out_val && out_rdy (in_rdy is 1 again in IDLE). No overlap of requests.
- Backpressure: out_rdy low holds DONE indefinitely; outputs do not change; in_rdy stays 0.
- Arithmetic invariants for non-error results:
  - dvd == quo*dvs + rem;
  - |rem| < |dvs|;
  - sign(rem) == sign(dvd) or rem==0.
- The most-negative dividend divided by a divisor other than -1 is valid: |dvd| fits in DVD_W unsigned bits.
- in_val while busy is ignored (no acceptance, no side effect).
- Quotient bits above DVD_W cannot occur: the quotient magnitude is <= |dvd|.

Test Plan:
- Unsigned, DVD_W=DVS_W=16: dvd=100, dvs=7, out_rdy=1 -> after edge 18: out_val=1, quo=14, rem=2, dbz=0, ovf=0; in_rdy=0 during edges 1..18.
- SIGNED=1, 16/16: dvd=-7, dvs=2 -> quo=-3 (0xFFFD), rem=-1 (0xFFFF). dvd=7, dvs=-2 -> quo=-3, rem=1.
- Divide by zero: dvd=0x1234, dvs=0 -> out_val after edge 2, quo=0xFFFF, rem=0x1234, dbz=1. Overflow (SIGNED=1): dvd=0x8000, dvs=0xFFFF -> quo=0x8000, rem=0, ovf=1.
- Backpressure: out_rdy=0 for 10 cycles after out_val -> quo/rem stable, in_rdy=0, new in_val ignored. Raise out_rdy -> out_val drops next edge. A subsequent request (dvd=9, dvs=3) then yields quo=3, rem=0.
- Reset mid-operation: assert rst at edge 5 of CALC -> next edge in_rdy=1, out_val=0, quo=0, rem=0. A new request (dvd=50, dvs=5) completes normally with quo=10, rem=0.
- Mixed widths and randomised checks:
  - DVD_W=24, DVS_W=8: dvd=0xFFFFFF, dvs=0xFF -> quo=0x010101, rem=0.
  - 1000 random back-to-back requests against a reference model, for both SIGNED settings.
